// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero finishes on the accepting edge with quotient = all ones and remainder = dividend.
module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_next;
  logic             accept;
  logic             last;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_work, r_work, d_work;
  logic [WIDTH-1:0] r_shift, r_next, q_next;
  logic [WIDTH:0]   trial;
  logic             no_borrow;

  // The bit shifted out of r_work is the top bit of the true partial remainder;
  // when it is set the partial remainder is at least 2^WIDTH > divisor, so it
  // must force a subtract even though the WIDTH-bit trial add shows a borrow.
  always_comb begin
    r_shift   = {r_work[WIDTH-2:0], q_work[WIDTH-1]};
    trial     = {1'b0, r_shift} + {1'b0, ~d_work} + {{WIDTH{1'b0}}, 1'b1};
    no_borrow = trial[WIDTH] | r_work[WIDTH-1];
    r_next    = no_borrow ? trial[WIDTH-1:0] : r_shift;
    q_next    = {q_work[WIDTH-2:0], no_borrow};
    last      = (count == CW'(WIDTH - 1));
  end

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    unique case (state)
      S_IDLE: accept = start;
      S_RUN: begin
        busy = 1'b1;
        if (last) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
        accept     = start;
      end
      default: state_next = S_IDLE;
    endcase
    if (accept) state_next = (divisor == '0) ? S_DONE : S_RUN;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      q_work      <= '0;
      r_work      <= '0;
      d_work      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        q_work <= dividend;
        r_work <= '0;
        d_work <= divisor;
        count  <= '0;
      end
    end else if (state == S_RUN) begin
      q_work <= q_next;
      r_work <= r_next;
      count  <= count + CW'(1);
      if (last) begin
        quotient    <= q_next;
        remainder   <= r_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases plus random
// operands compared against plain integer division.
module tb_seq_restoring_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: present a request for the next rising edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
  endtask

  // Waits for the request presented by launch() to complete and checks it.
  // lat counts rising edges after the accepting edge until done is seen:
  // a real divide needs W of them, a zero divisor finishes on the accepting edge.
  task automatic complete(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at, input string tag);
    int            lat;
    bit            seen;
    logic [W-1:0]  exp_q, exp_r;
    logic [63:0]   recon;
    exp_q = (b == 0) ? '1 : a / b;
    exp_r = (b == 0) ? a  : a % b;
    @(posedge clk);
    #1 start = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      check({tag, "_busy_run"}, busy, 1);
      if (lat == inject_at) launch($urandom, $urandom | 1);
      @(posedge clk);
      lat++;
      #1 start = 1'b0;
    end
    check({tag, "_done_seen"}, seen, 1);
    if (!seen) return;
    check({tag, "_latency"}, lat, (b == 0) ? 0 : W);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_q"}, quotient, exp_q);
    check({tag, "_r"}, remainder, exp_r);
    check({tag, "_dbz"}, div_by_zero, (b == 0));
    if (b != 0) begin
      recon = 64'(quotient) * 64'(b) + 64'(remainder);
      check({tag, "_reconstruct"}, recon, 64'(a));
      check({tag, "_r_lt_d"}, (remainder < b), 1);
    end
  endtask

  // One cycle after a lone done: pulse has ended and results are held.
  task automatic check_idle_hold(input logic [W-1:0] q, input logic [W-1:0] r, input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_q_hold"}, quotient, q);
    check({tag, "_r_hold"}, remainder, r);
  endtask

  initial begin
    logic [W-1:0] a, b;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_done", done, 0);

    // Basic divide.
    launch(32'h4288_4743, 32'h0000_0007);
    complete(32'h4288_4743, 32'h0000_0007, -1, "tp1");
    check("tp1_q_const", quotient, 32'h0981_2EC0);
    check("tp1_r_const", remainder, 32'h0000_0003);
    check_idle_hold(32'h0981_2EC0, 32'h3, "tp1");

    // Equal operands, then a back-to-back start during the done cycle.
    @(negedge clk);
    launch(32'hF28A_47B3, 32'hF28A_47B3);
    complete(32'hF28A_47B3, 32'hF28A_47B3, -1, "tp2a");
    launch(32'h0000_000A, 32'h4B8B_47A3);
    complete(32'h0000_000A, 32'h4B8B_47A3, -1, "tp2b");
    check_idle_hold(32'h0, 32'hA, "tp2b");

    // Divide by zero, then a valid divide clears the flag.
    @(negedge clk);
    launch(32'h9B8B_47AB, 32'h0);
    complete(32'h9B8B_47AB, 32'h0, -1, "tp3z");
    check_idle_hold(32'hFFFF_FFFF, 32'h9B8B_47AB, "tp3z");
    @(negedge clk);
    launch(32'd100, 32'd7);
    complete(32'd100, 32'd7, -1, "tp3v");

    // Full-range quotient, with a stray start mid-run that must be ignored.
    @(negedge clk);
    launch(32'hFFFF_FFFF, 32'h1);
    complete(32'hFFFF_FFFF, 32'h1, 10, "tp4");
    check_idle_hold(32'hFFFF_FFFF, 32'h0, "tp4");

    // Asynchronous reset mid-run aborts without a done pulse.
    @(negedge clk);
    launch(32'h1234_5678, 32'h0000_0035);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    check("arst_dbz", div_by_zero, 0);
    repeat (3) begin
      @(negedge clk);
      check("arst_no_done", done, 0);
    end
    rst = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      check("arst_idle_quiet", done | busy, 0);
    end
    launch(32'h4288_4743, 32'h0000_0007);
    complete(32'h4288_4743, 32'h0000_0007, -1, "tp5");

    // Random operands, roughly 5% zero divisors and a mix of divisor sizes.
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      case ($urandom_range(0, 19))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 15));
        3, 4:    b = $urandom | 32'h8000_0000;
        5:       b = a;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      @(negedge clk);
      launch(a, b);
      complete(a, b, (n % 7 == 0) ? $urandom_range(0, W - 2) : -1, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
